alu_cmd_dispatch: RTL and testbench

- Front-end sequencer that sits directly upstream of the ALU.
- Accepts operation commands over a valid/ready interface and buffers them in a small FIFO.
- Drives the ALU `start_alu`/`op`/`A`/`B` beat sequence, including the two-beat operand protocol of the IEEE754 operation.
- Collects `result`/`error_alu` on `valid_alu` and returns one tagged response per command, with timeout protection.

---
 rtl/alu_cmd_dispatch.sv | 290 +++++++++++++++++++++++++++++
 tb/tb_alu_cmd_dispatch.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_dispatch.sv
// Command sequencer in front of the ALU: queues tagged commands, drives the
// start/op/A/B beat sequence (two operand beats for FP_OP), returns one response per command.
module alu_cmd_dispatch #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TAG_W   = 4,
  parameter int unsigned TIMEOUT = 1023,
  parameter logic [4:0]  FP_OP   = 5'b01000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [4:0]       cmd_op,
  input  logic             cmd_fp,
  input  logic             cmd_rs1_signed,
  input  logic             cmd_rs2_signed,
  input  logic [WIDTH-1:0] cmd_a0,
  input  logic [WIDTH-1:0] cmd_b0,
  input  logic [WIDTH-1:0] cmd_a1,
  input  logic [WIDTH-1:0] cmd_b1,
  input  logic [TAG_W-1:0] cmd_tag,
  output logic             start_alu,
  output logic             rs1_signed,
  output logic             rs2_signed,
  output logic             operation_ieee754_or_integer,
  output logic [4:0]       op,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  input  logic             busy_alu,
  input  logic             valid_alu,
  input  logic             error_alu,
  input  logic [WIDTH-1:0] result,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_err,
  output logic             rsp_timeout
);

  localparam int unsigned AW = (DEPTH < 2) ? 1 : $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef struct packed {
    logic [4:0]       op;
    logic             fp;
    logic             s1;
    logic             s2;
    logic [WIDTH-1:0] a0;
    logic [WIDTH-1:0] b0;
    logic [WIDTH-1:0] a1;
    logic [WIDTH-1:0] b1;
    logic [TAG_W-1:0] tag;
  } entry_t;

  typedef enum logic [2:0] {S_IDLE, S_ISSUE0, S_ISSUE1, S_WAIT, S_RESP} state_t;

  // Command FIFO
  entry_t         r_mem [DEPTH];
  entry_t         w_wr_ent;
  entry_t         w_head;
  logic [AW-1:0]  r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]  r_count, w_count_nxt;
  logic           r_cmd_ready;
  logic           w_push, w_pop;

  always_comb begin
    w_wr_ent     = '0;
    w_wr_ent.op  = cmd_op;
    w_wr_ent.fp  = cmd_fp;
    w_wr_ent.s1  = cmd_rs1_signed;
    w_wr_ent.s2  = cmd_rs2_signed;
    w_wr_ent.a0  = cmd_a0;
    w_wr_ent.b0  = cmd_b0;
    w_wr_ent.a1  = cmd_a1;
    w_wr_ent.b1  = cmd_b1;
    w_wr_ent.tag = cmd_tag;
  end

  assign w_push = cmd_valid && r_cmd_ready;
  assign w_head = r_mem[r_rd_ptr];

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop)      w_count_nxt = r_count + CW'(1);
    else if (!w_push && w_pop) w_count_nxt = r_count - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_wr_ent;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_cmd_ready <= 1'b1;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count     <= w_count_nxt;
      r_cmd_ready <= (w_count_nxt != CW'(DEPTH));
    end
  end

  // Sequencer state and registered outputs
  state_t           r_state, w_state_nxt;
  logic             r_start, w_start_nxt;
  logic [4:0]       r_op, w_op_nxt;
  logic             r_fp, w_fp_nxt, r_s1, w_s1_nxt, r_s2, w_s2_nxt;
  logic [WIDTH-1:0] r_a, w_a_nxt, r_b, w_b_nxt, r_a1, w_a1_nxt, r_b1, w_b1_nxt;
  logic [TAG_W-1:0] r_tag, w_tag_nxt;
  logic             r_beat, w_beat_nxt;
  logic             r_got, w_got_nxt;
  logic [TW-1:0]    r_tcnt, w_tcnt_nxt, w_tcnt_inc;
  logic             r_rsp_valid, w_rsp_valid_nxt;
  logic [WIDTH-1:0] r_rsp_result, w_rsp_result_nxt;
  logic [TAG_W-1:0] r_rsp_tag, w_rsp_tag_nxt;
  logic             r_rsp_err, w_rsp_err_nxt;
  logic             r_rsp_timeout, w_rsp_timeout_nxt;

  assign w_tcnt_inc = r_tcnt + TW'(1);

  always_comb begin
    w_state_nxt       = r_state;
    w_pop             = 1'b0;
    w_start_nxt       = 1'b0;
    w_op_nxt          = r_op;
    w_fp_nxt          = r_fp;
    w_s1_nxt          = r_s1;
    w_s2_nxt          = r_s2;
    w_a_nxt           = r_a;
    w_b_nxt           = r_b;
    w_a1_nxt          = r_a1;
    w_b1_nxt          = r_b1;
    w_tag_nxt         = r_tag;
    w_beat_nxt        = r_beat;
    w_got_nxt         = r_got;
    w_tcnt_nxt        = r_tcnt;
    w_rsp_valid_nxt   = r_rsp_valid;
    w_rsp_result_nxt  = r_rsp_result;
    w_rsp_tag_nxt     = r_rsp_tag;
    w_rsp_err_nxt     = r_rsp_err;
    w_rsp_timeout_nxt = r_rsp_timeout;

    // A completion seen while still issuing is kept until the beats finish
    if ((r_state == S_ISSUE0 || r_state == S_ISSUE1 || r_state == S_WAIT) && valid_alu) begin
      w_got_nxt         = 1'b1;
      w_rsp_result_nxt  = result;
      w_rsp_err_nxt     = error_alu;
      w_rsp_timeout_nxt = 1'b0;
    end

    case (r_state)
      S_IDLE: begin
        if (r_count != '0 && !busy_alu) begin
          w_pop       = 1'b1;
          w_start_nxt = 1'b1;
          w_op_nxt    = w_head.op;
          w_fp_nxt    = w_head.fp;
          w_s1_nxt    = w_head.s1;
          w_s2_nxt    = w_head.s2;
          w_a_nxt     = w_head.a0;
          w_b_nxt     = w_head.b0;
          w_a1_nxt    = w_head.a1;
          w_b1_nxt    = w_head.b1;
          w_tag_nxt   = w_head.tag;
          w_beat_nxt  = 1'b0;
          w_got_nxt   = 1'b0;
          w_state_nxt = S_ISSUE0;
        end
      end
      S_ISSUE0: begin
        if (r_op == FP_OP && !r_beat) begin
          w_beat_nxt  = 1'b1;
          w_start_nxt = 1'b1;
        end else if (r_op == FP_OP) begin
          w_start_nxt = 1'b1;
          w_a_nxt     = r_a1;
          w_b_nxt     = r_b1;
          w_state_nxt = S_ISSUE1;
        end else if (r_got || valid_alu) begin
          w_rsp_valid_nxt = 1'b1;
          w_rsp_tag_nxt   = r_tag;
          w_state_nxt     = S_RESP;
        end else begin
          w_tcnt_nxt  = '0;
          w_state_nxt = S_WAIT;
        end
      end
      S_ISSUE1: begin
        if (r_got || valid_alu) begin
          w_rsp_valid_nxt = 1'b1;
          w_rsp_tag_nxt   = r_tag;
          w_state_nxt     = S_RESP;
        end else begin
          w_tcnt_nxt  = '0;
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        w_tcnt_nxt = w_tcnt_inc;
        if (valid_alu) begin
          w_rsp_valid_nxt = 1'b1;
          w_rsp_tag_nxt   = r_tag;
          w_state_nxt     = S_RESP;
        end else if (w_tcnt_inc == TW'(TIMEOUT)) begin
          w_rsp_result_nxt  = '0;
          w_rsp_err_nxt     = 1'b0;
          w_rsp_timeout_nxt = 1'b1;
          w_rsp_valid_nxt   = 1'b1;
          w_rsp_tag_nxt     = r_tag;
          w_state_nxt       = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          w_rsp_valid_nxt = 1'b0;
          w_state_nxt     = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_start       <= 1'b0;
      r_op          <= '0;
      r_fp          <= 1'b0;
      r_s1          <= 1'b0;
      r_s2          <= 1'b0;
      r_a           <= '0;
      r_b           <= '0;
      r_a1          <= '0;
      r_b1          <= '0;
      r_tag         <= '0;
      r_beat        <= 1'b0;
      r_got         <= 1'b0;
      r_tcnt        <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_result  <= '0;
      r_rsp_tag     <= '0;
      r_rsp_err     <= 1'b0;
      r_rsp_timeout <= 1'b0;
    end else begin
      r_start       <= w_start_nxt;
      r_op          <= w_op_nxt;
      r_fp          <= w_fp_nxt;
      r_s1          <= w_s1_nxt;
      r_s2          <= w_s2_nxt;
      r_a           <= w_a_nxt;
      r_b           <= w_b_nxt;
      r_a1          <= w_a1_nxt;
      r_b1          <= w_b1_nxt;
      r_tag         <= w_tag_nxt;
      r_beat        <= w_beat_nxt;
      r_got         <= w_got_nxt;
      r_tcnt        <= w_tcnt_nxt;
      r_rsp_valid   <= w_rsp_valid_nxt;
      r_rsp_result  <= w_rsp_result_nxt;
      r_rsp_tag     <= w_rsp_tag_nxt;
      r_rsp_err     <= w_rsp_err_nxt;
      r_rsp_timeout <= w_rsp_timeout_nxt;
    end
  end

  assign cmd_ready                    = r_cmd_ready;
  assign start_alu                    = r_start;
  assign op                           = r_op;
  assign operation_ieee754_or_integer = r_fp;
  assign rs1_signed                   = r_s1;
  assign rs2_signed                   = r_s2;
  assign A                            = r_a;
  assign B                            = r_b;
  assign rsp_valid                    = r_rsp_valid;
  assign rsp_result                   = r_rsp_result;
  assign rsp_tag                      = r_rsp_tag;
  assign rsp_err                      = r_rsp_err;
  assign rsp_timeout                  = r_rsp_timeout;

endmodule

// File: tb/tb_alu_cmd_dispatch.sv
// Directed bench for alu_cmd_dispatch with a small ALU responder model.
module tb_alu_cmd_dispatch;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [4:0]  cmd_op = '0;
  logic        cmd_fp = 1'b0;
  logic        cmd_rs1_signed = 1'b0;
  logic        cmd_rs2_signed = 1'b0;
  logic [31:0] cmd_a0 = '0, cmd_b0 = '0, cmd_a1 = '0, cmd_b1 = '0;
  logic [3:0]  cmd_tag = '0;
  logic        start_alu, rs1_signed, rs2_signed, operation_ieee754_or_integer;
  logic [4:0]  op;
  logic [31:0] A, B;
  logic        busy_alu = 1'b0;
  logic        valid_alu = 1'b0;
  logic        error_alu = 1'b0;
  logic [31:0] result = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_result;
  logic [3:0]  rsp_tag;
  logic        rsp_err, rsp_timeout;

  int n_cmp = 0;
  int n_bad = 0;

  // ALU responder: answers two cycles after the last start beat
  logic        m_en = 1'b0, m_echo = 1'b0, m_err = 1'b0;
  logic [31:0] m_res = '0, m_a = '0;
  int          m_cnt = 0;
  logic [63:0] q_ab[$];

  always #5 clk = ~clk;

  alu_cmd_dispatch #(.WIDTH(32), .DEPTH(4), .TAG_W(4), .TIMEOUT(15), .FP_OP(5'b01000)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_fp(cmd_fp),
    .cmd_rs1_signed(cmd_rs1_signed), .cmd_rs2_signed(cmd_rs2_signed),
    .cmd_a0(cmd_a0), .cmd_b0(cmd_b0), .cmd_a1(cmd_a1), .cmd_b1(cmd_b1), .cmd_tag(cmd_tag),
    .start_alu(start_alu), .rs1_signed(rs1_signed), .rs2_signed(rs2_signed),
    .operation_ieee754_or_integer(operation_ieee754_or_integer),
    .op(op), .A(A), .B(B),
    .busy_alu(busy_alu), .valid_alu(valid_alu), .error_alu(error_alu), .result(result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_tag(rsp_tag), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout)
  );

  always @(negedge clk) begin
    valid_alu = 1'b0;
    if (!rst) begin
      m_cnt = 0;
    end else if (start_alu) begin
      m_cnt = 2;
      m_a   = A;
    end else if (m_cnt > 0) begin
      m_cnt = m_cnt - 1;
      if (m_cnt == 0 && m_en) begin
        valid_alu = 1'b1;
        result    = m_echo ? (m_a ^ 32'h5A5A0000) : m_res;
        error_alu = m_err;
      end
    end
  end

  always @(negedge clk) begin
    if (rst && start_alu) q_ab.push_back({A, B});
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [4:0] opc, input logic fp, input logic sg,
                      input logic [31:0] a0, input logic [31:0] b0,
                      input logic [31:0] a1, input logic [31:0] b1,
                      input logic [3:0] tag, output logic rdy);
    cmd_op = opc; cmd_fp = fp; cmd_rs1_signed = sg; cmd_rs2_signed = sg;
    cmd_a0 = a0; cmd_b0 = b0; cmd_a1 = a1; cmd_b1 = b1; cmd_tag = tag;
    cmd_valid = 1'b1;
    rdy = cmd_ready;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic take_rsp(input string nm, input logic [3:0] tag, input logic [31:0] res,
                          input logic err, input logic to);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (rsp_valid) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    chk({nm, "_seen"}, 64'(ok), 64'd1);
    if (ok) begin
      chk({nm, "_tag"}, 64'(rsp_tag), 64'(tag));
      chk({nm, "_res"}, 64'(rsp_result), 64'(res));
      chk({nm, "_err"}, 64'(rsp_err), 64'(err));
      chk({nm, "_to"},  64'(rsp_timeout), 64'(to));
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk({nm, "_clr"}, 64'(rsp_valid), 64'd0);
  endtask

  initial begin
    logic        rdy;
    logic [31:0] v;
    int          wc;

    // Reset values
    step(); step();
    chk("rst_ready", 64'(cmd_ready), 64'd1);
    chk("rst_start", 64'(start_alu), 64'd0);
    chk("rst_rspv",  64'(rsp_valid), 64'd0);
    chk("rst_A",     64'(A), 64'd0);
    chk("rst_op",    64'(op), 64'd0);
    chk("rst_res",   64'(rsp_result), 64'd0);
    rst = 1'b1;
    step();

    // AND, single beat
    m_en = 1'b1; m_echo = 1'b0; m_err = 1'b0; m_res = 32'h02000014;
    q_ab.delete();
    push(5'b00000, 1'b0, 1'b0, 32'h0A010114, 32'h06020014, 32'h0, 32'h0, 4'd3, rdy);
    chk("and_rdy", 64'(rdy), 64'd1);
    chk("and_n1_start", 64'(start_alu), 64'd0);
    step();
    chk("and_start", 64'(start_alu), 64'd1);
    chk("and_A", 64'(A), 64'h0A010114);
    chk("and_B", 64'(B), 64'h06020014);
    chk("and_op", 64'(op), 64'd0);
    step();
    chk("and_start_off", 64'(start_alu), 64'd0);
    chk("and_A_hold", 64'(A), 64'h0A010114);
    take_rsp("and", 4'd3, 32'h02000014, 1'b0, 1'b0);
    chk("and_nstart", 64'(q_ab.size()), 64'd1);

    // FP two-beat
    m_res = 32'h47EA3B9A;
    q_ab.delete();
    push(5'b01000, 1'b1, 1'b1, 32'h0000062C, 32'hA9D49600, 32'h0000004B, 32'hDF166000, 4'd9, rdy);
    step();
    chk("fp_s0", 64'(start_alu), 64'd1);
    chk("fp_ab0", {A, B}, {32'h0000062C, 32'hA9D49600});
    chk("fp_ctl", 64'({operation_ieee754_or_integer, rs1_signed, rs2_signed, op}), 64'({3'b111, 5'b01000}));
    step();
    chk("fp_s1", 64'(start_alu), 64'd1);
    chk("fp_ab1", {A, B}, {32'h0000062C, 32'hA9D49600});
    step();
    chk("fp_s2", 64'(start_alu), 64'd1);
    chk("fp_ab2", {A, B}, {32'h0000004B, 32'hDF166000});
    step();
    chk("fp_s3", 64'(start_alu), 64'd0);
    take_rsp("fp", 4'd9, 32'h47EA3B9A, 1'b0, 1'b0);
    chk("fp_nstart", 64'(q_ab.size()), 64'd3);

    // FIFO full and ordering
    busy_alu = 1'b1; m_echo = 1'b1;
    q_ab.delete();
    cmd_op = 5'b00010; cmd_fp = 1'b0; cmd_rs1_signed = 1'b0; cmd_rs2_signed = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      cmd_tag = 4'(k);
      cmd_a0 = 32'h11111111 * 32'(k);
      cmd_valid = 1'b1;
      chk($sformatf("fifo_rdy%0d", k), 64'(cmd_ready), 64'(k <= 4));
      step();
    end
    for (int i = 0; i < 3; i++) begin
      chk("fifo_stall_rdy", 64'(cmd_ready), 64'd0);
      chk("fifo_stall_start", 64'(start_alu), 64'd0);
      step();
    end
    busy_alu = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (cmd_ready) break;
      step();
    end
    chk("fifo_rdy_back", 64'(cmd_ready), 64'd1);
    step();
    cmd_valid = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      v = (32'h11111111 * 32'(k)) ^ 32'h5A5A0000;
      take_rsp($sformatf("fifo%0d", k), 4'(k), v, 1'b0, 1'b0);
    end
    chk("fifo_nstart", 64'(q_ab.size()), 64'd5);

    // Timeout
    m_en = 1'b0; m_echo = 1'b0;
    push(5'b00000, 1'b0, 1'b0, 32'h1, 32'h2, 32'h0, 32'h0, 4'd7, rdy);
    step();
    chk("to_start", 64'(start_alu), 64'd1);
    step();
    wc = 0;
    while (!rsp_valid && wc < 40) begin
      wc++;
      step();
    end
    chk("to_wait_cycles", 64'(wc), 64'd15);
    take_rsp("to", 4'd7, 32'h0, 1'b0, 1'b1);
    m_en = 1'b1; m_res = 32'hCAFEF00D;
    push(5'b00001, 1'b0, 1'b0, 32'h5, 32'h6, 32'h0, 32'h0, 4'd8, rdy);
    take_rsp("post_to", 4'd8, 32'hCAFEF00D, 1'b0, 1'b0);

    // Response back-pressure with a second command queued
    m_err = 1'b1; m_res = 32'h0BAD0001;
    push(5'b00011, 1'b0, 1'b0, 32'h10, 32'h20, 32'h0, 32'h0, 4'd10, rdy);
    push(5'b00011, 1'b0, 1'b0, 32'h30, 32'h40, 32'h0, 32'h0, 4'd11, rdy);
    chk("bp_rdy2", 64'(rdy), 64'd1);
    wc = 0;
    while (!rsp_valid && wc < 40) begin
      wc++;
      step();
    end
    chk("bp_seen", 64'(rsp_valid), 64'd1);
    m_err = 1'b0; m_res = 32'h0BAD0002;
    for (int i = 0; i < 10; i++) begin
      chk("bp_hold_v", 64'(rsp_valid), 64'd1);
      chk("bp_hold_d", 64'({rsp_tag, rsp_err, rsp_result}), 64'({4'd10, 1'b1, 32'h0BAD0001}));
      chk("bp_no_start", 64'(start_alu), 64'd0);
      step();
    end
    take_rsp("bp1", 4'd10, 32'h0BAD0001, 1'b1, 1'b0);
    take_rsp("bp2", 4'd11, 32'h0BAD0002, 1'b0, 1'b0);

    // Reset while waiting, with the FIFO full behind the in-flight command
    m_en = 1'b0; busy_alu = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      push(5'b00000, 1'b0, 1'b0, 32'(k), 32'(k), 32'h0, 32'h0, 4'(k), rdy);
      chk("rw_rdy", 64'(rdy), 64'd1);
    end
    busy_alu = 1'b0;
    step();
    chk("rw_issue", 64'(start_alu), 64'd1);
    push(5'b00000, 1'b0, 1'b0, 32'h5, 32'h5, 32'h0, 32'h0, 4'd5, rdy);
    chk("rw_rdy5", 64'(rdy), 64'd1);
    step();
    chk("rw_full", 64'(cmd_ready), 64'd0);
    chk("rw_wait", 64'(start_alu), 64'd0);
    #3 rst = 1'b0;
    #1;
    chk("rw_start0", 64'(start_alu), 64'd0);
    chk("rw_rspv0",  64'(rsp_valid), 64'd0);
    chk("rw_ready1", 64'(cmd_ready), 64'd1);
    chk("rw_A0",     64'(A), 64'd0);
    step(); step();
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("rw_empty_start", 64'(start_alu), 64'd0);
      chk("rw_empty_rspv", 64'(rsp_valid), 64'd0);
      chk("rw_empty_rdy", 64'(cmd_ready), 64'd1);
    end
    m_en = 1'b1; m_res = 32'h00000010;
    push(5'b00000, 1'b0, 1'b0, 32'h000000F0, 32'h0000001F, 32'h0, 32'h0, 4'd2, rdy);
    chk("rw_and_rdy", 64'(rdy), 64'd1);
    step();
    chk("rw_and_A", {A, B}, {32'h000000F0, 32'h0000001F});
    take_rsp("rw_and", 4'd2, 32'h00000010, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
